// File: rtl/sym_timing_nco_pkg.sv
// ----------------------------------------------------------------------------
// sym_timing_pkg
// Shared types, constants and helpers for the symbol-timing NCO.
//   phase_t    : Q(INT_W).(FRAC_W) phase pointer at the default geometry
//   step_t     : signed step, two guard bits above the phase pointer
//   ONE_SAMPLE : one sample in phase LSBs
//   STEP_MAX   : largest allowed step, two samples
//   osf_clamp(): limits a requested OSF to the legal range [2, osf_max]
// ----------------------------------------------------------------------------
package sym_timing_pkg;

  localparam int INT_W_DEF  = 5;
  localparam int FRAC_W_DEF = 27;

  typedef logic        [INT_W_DEF+FRAC_W_DEF-1:0] phase_t;
  typedef logic signed [INT_W_DEF+FRAC_W_DEF+1:0] step_t;

  localparam step_t ONE_SAMPLE = step_t'(1) << FRAC_W_DEF;
  localparam step_t STEP_MAX   = step_t'(2) << FRAC_W_DEF;

  function automatic int unsigned osf_clamp(input int unsigned osf,
                                            input int unsigned osf_max);
    if (osf < 2)            return 2;
    else if (osf > osf_max) return osf_max;
    else                    return osf;
  endfunction

endpackage

// File: rtl/sym_timing_nco_if.sv
// ----------------------------------------------------------------------------
// sym_timing_nco_if
// Control and result bundle of the symbol-timing NCO.
//   master : loop filter / sample front end (drives *_i, observes *_o)
//   slave  : the NCO itself
// Inputs : samp_en_i, osf_i, ctrl_i, ctrl_val_i, cnt_clr_i
// Outputs: sym_valid_o, phase_int_o, mu_o, step_sat_o,
//          early_cnt_o, late_cnt_o, sym_len_o
// ----------------------------------------------------------------------------
interface sym_timing_nco_if #(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 27,
  parameter int CTRL_W = 18,
  parameter int CNT_W  = 16
);

  logic                     samp_en_i;
  logic [INT_W-1:0]         osf_i;
  logic signed [CTRL_W-1:0] ctrl_i;
  logic                     ctrl_val_i;
  logic                     cnt_clr_i;

  logic                     sym_valid_o;
  logic [INT_W-1:0]         phase_int_o;
  logic [FRAC_W-1:0]        mu_o;
  logic                     step_sat_o;
  logic [CNT_W-1:0]         early_cnt_o;
  logic [CNT_W-1:0]         late_cnt_o;
  logic [INT_W:0]           sym_len_o;

  modport master (
    output samp_en_i, osf_i, ctrl_i, ctrl_val_i, cnt_clr_i,
    input  sym_valid_o, phase_int_o, mu_o, step_sat_o,
           early_cnt_o, late_cnt_o, sym_len_o
  );

  modport slave (
    input  samp_en_i, osf_i, ctrl_i, ctrl_val_i, cnt_clr_i,
    output sym_valid_o, phase_int_o, mu_o, step_sat_o,
           early_cnt_o, late_cnt_o, sym_len_o
  );

endinterface

// File: rtl/sym_timing_nco_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the early/late slip statistics.
//   clk, reset : sample clock, synchronous active-high reset
//   i_inc      : count one event
//   i_clr      : zero the counter (wins over i_inc)
//   o_cnt      : current count, sticks at 2^CNT_W-1
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sym_timing_nco.sv
// ----------------------------------------------------------------------------
// sym_timing_nco
// Symbol-timing NCO. Advances a Q(INT_W).(FRAC_W) phase pointer by one sample
// plus a clamped loop-filter correction on every enabled sample, wraps it at
// OSF samples and strobes the integer phase and mu for the interpolator.
//   clk, reset : sample clock, synchronous active-high reset
//   bus        : sym_timing_nco_if slave (inputs samp_en/osf/ctrl/ctrl_val/
//                cnt_clr; outputs strobe, phase, mu, step_sat, slip counters,
//                last symbol length). All outputs are registered.
// ----------------------------------------------------------------------------
module sym_timing_nco
  import sym_timing_pkg::*;
#(
  parameter int INT_W      = INT_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int CTRL_W     = 18,
  parameter int CTRL_SHIFT = 15,
  parameter int OSF_DEF    = 20,
  parameter bit CTRL_HOLD  = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            reset,
  sym_timing_nco_if.slave bus
);

  localparam int PW = INT_W + FRAC_W;       // phase pointer width
  localparam int SW = INT_W + FRAC_W + 2;   // signed step / sum width

  localparam logic signed [SW-1:0] L_ONE      = SW'(1) << FRAC_W;
  localparam logic signed [SW-1:0] L_STEP_MAX = SW'(2) << FRAC_W;
  localparam logic [INT_W:0]       L_LEN_ONE  = (INT_W+1)'(1);

  logic [PW-1:0]            r_phi;
  logic signed [CTRL_W-1:0] r_ctrl_q;
  logic [INT_W-1:0]         r_osf_act;
  logic [INT_W:0]           r_interval;
  logic [INT_W:0]           r_sym_len;
  logic                     r_sym_valid;
  logic                     r_step_sat;

  logic signed [SW-1:0] w_ctrl_ext;
  logic signed [SW-1:0] w_step_raw;
  logic signed [SW-1:0] w_step;
  logic                 w_step_clamped;
  logic [SW-1:0]        w_phi_next;
  logic [SW-1:0]        w_osf_full;
  logic                 w_wrap;
  logic [INT_W:0]       w_len;
  logic                 w_early;
  logic                 w_late;
  logic [INT_W-1:0]     w_osf_new;

  // Any CTRL_W correction shifted into phase units fits the step width, so
  // the only range limit needed is the clamp on the final step.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_ctrl_ext     = SW'(r_ctrl_q) <<< CTRL_SHIFT;
    w_step_raw     = L_ONE + w_ctrl_ext;
    w_step         = w_step_raw;
    w_step_clamped = 1'b0;
    if (w_step_raw[SW-1]) begin
      w_step         = '0;
      w_step_clamped = 1'b1;
    end else if (w_step_raw > L_STEP_MAX) begin
      w_step         = L_STEP_MAX;
      w_step_clamped = 1'b1;
    end
  end

  assign w_phi_next = {2'b00, r_phi} + $unsigned(w_step);
  assign w_osf_full = {2'b00, r_osf_act, {FRAC_W{1'b0}}};
  assign w_wrap     = bus.samp_en_i && (w_phi_next >= w_osf_full);

  // Sample count of the symbol ending now (this cycle included); sticks at
  // all-ones while the phase is frozen instead of rolling over.
  assign w_len   = (&r_interval) ? r_interval : r_interval + L_LEN_ONE;
  assign w_early = w_wrap && (w_len < {1'b0, r_osf_act});
  assign w_late  = w_wrap && (w_len > {1'b0, r_osf_act});

  assign w_osf_new = INT_W'(osf_clamp(32'(bus.osf_i), 32'((1 << INT_W) - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phi       <= '0;
      r_ctrl_q    <= '0;
      r_osf_act   <= INT_W'(OSF_DEF);
      r_interval  <= '0;
      r_sym_len   <= '0;
      r_sym_valid <= 1'b0;
      r_step_sat  <= 1'b0;
    end else begin
      if (bus.samp_en_i) begin
        r_step_sat <= w_step_clamped;
        if (w_wrap) begin
          // The subtraction uses the OSF of the symbol just completed; the
          // requested OSF only governs the next one.
          r_phi      <= PW'(w_phi_next - w_osf_full);
          r_osf_act  <= w_osf_new;
          r_interval <= '0;
          r_sym_len  <= w_len;
        end else begin
          r_phi      <= PW'(w_phi_next);
          r_interval <= w_len;
        end
      end
      r_sym_valid <= w_wrap;
      // A fresh load beats the one-shot consume in the same cycle.
      if (bus.ctrl_val_i) begin
        r_ctrl_q <= bus.ctrl_i;
      end else if (!CTRL_HOLD && bus.samp_en_i) begin
        r_ctrl_q <= '0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_early_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_early),
    .i_clr (bus.cnt_clr_i),
    .o_cnt (bus.early_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_late_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_late),
    .i_clr (bus.cnt_clr_i),
    .o_cnt (bus.late_cnt_o)
  );

  assign bus.sym_valid_o = r_sym_valid;
  assign bus.phase_int_o = r_phi[PW-1:FRAC_W];
  assign bus.mu_o        = r_phi[FRAC_W-1:0];
  assign bus.step_sat_o  = r_step_sat;
  assign bus.sym_len_o   = r_sym_len;

endmodule
